// File: rtl/smem_result_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : smem_result_packer_if
//  Description : Token-in / cache-line-out bundle of the SMEM result packer.
//                slave = packer side, master = pipeline + host write path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface smem_result_packer_if #(
    parameter int READ_NUM_WIDTH = 8
);
    logic                      token_valid;
    logic [63:0]               token_data;
    logic [READ_NUM_WIDTH-1:0] token_read_num;
    logic                      token_last;
    logic                      flush;
    logic                      stall;
    logic                      cl_valid;
    logic                      cl_ready;
    logic [511:0]              cl_data;
    logic [READ_NUM_WIDTH-1:0] cl_read_num;
    logic [3:0]                cl_words;
    logic                      cl_last;
    logic [31:0]               lines_out;

    modport slave (
        input  token_valid, token_data, token_read_num, token_last, flush, cl_ready,
        output stall, cl_valid, cl_data, cl_read_num, cl_words, cl_last, lines_out
    );

    modport master (
        output token_valid, token_data, token_read_num, token_last, flush, cl_ready,
        input  stall, cl_valid, cl_data, cl_read_num, cl_words, cl_last, lines_out
    );
endinterface
`default_nettype wire

// File: rtl/smem_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : smem_result_packer
//  Description : Packs 64-bit SMEM result tokens (tagged per read) into
//                512-bit cache lines, buffers them in a DEPTH-entry FIFO and
//                drives the pipeline stall. Optional macro SMEM_PACK_HDR_EN
//                puts a header in word 0 and limits payload to 7 words.
//  Revision    : 1.0 - initial release
// ============================================================================
module smem_result_packer #(
    parameter int DEPTH          = 4,
    parameter int READ_NUM_WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    smem_result_packer_if.slave bus
);
    localparam int            c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw+1)'(DEPTH);
`ifdef SMEM_PACK_HDR_EN
    localparam logic [3:0]    c_nw   = 4'd7;
    localparam logic [2:0]    c_base = 3'd1;
`else
    localparam logic [3:0]    c_nw   = 4'd8;
    localparam logic [2:0]    c_base = 3'd0;
`endif

    // packer state
    logic [511:0]              pk_data_q, pk_data_d;
    logic [3:0]                wr_idx_q, wr_idx_d;
    logic [READ_NUM_WIDTH-1:0] cur_read_q, cur_read_d;
    logic                      pend_q, pend_d;
    logic                      fpend_q, fpend_d;

    // line FIFO
    logic [511:0]              fifo_data_q  [DEPTH];
    logic [READ_NUM_WIDTH-1:0] fifo_num_q   [DEPTH];
    logic [3:0]                fifo_words_q [DEPTH];
    logic                      fifo_last_q  [DEPTH];
    logic [c_aw-1:0]           wr_ptr_q, rd_ptr_q;
    logic [c_aw:0]             count_q;
    logic [31:0]               lines_q;

    logic                      w_stall, w_accept, w_flush_req, w_valid, w_pop;
    logic                      w_natural, w_push, w_push_last;
    logic [3:0]                w_new_idx, w_push_words;
    logic [8:0]                w_off;
    logic [511:0]              w_tok_line, w_new_line, w_push_data, w_push_out;
    logic [READ_NUM_WIDTH-1:0] w_push_num;

    // A pending one-word line holds the pipeline until it reaches the FIFO.
    assign w_stall     = (count_q == c_full) || pend_q;
    assign w_accept    = bus.token_valid && !w_stall;
    assign w_flush_req = bus.flush || fpend_q;
    assign w_valid     = (count_q != '0);
    assign w_pop       = w_valid && bus.cl_ready;
    assign w_new_idx   = wr_idx_q + 4'd1;
    assign w_natural   = (w_new_idx == c_nw) || bus.token_last;
    assign w_off       = {wr_idx_q[2:0] + c_base, 6'd0};

    // Candidate lines: token appended to packer, or token starting a new line.
    always_comb begin
        w_tok_line                       = pk_data_q;
        w_tok_line[w_off +: 64]          = bus.token_data;
        w_new_line                       = '0;
        w_new_line[{c_base, 6'd0} +: 64] = bus.token_data;
    end

    // Packer next state and FIFO push selection; at most one push per cycle.
    always_comb begin
        pk_data_d    = pk_data_q;
        wr_idx_d     = wr_idx_q;
        cur_read_d   = cur_read_q;
        pend_d       = pend_q;
        fpend_d      = w_flush_req;
        w_push       = 1'b0;
        w_push_data  = pk_data_q;
        w_push_num   = cur_read_q;
        w_push_words = wr_idx_q;
        w_push_last  = 1'b0;
        if (pend_q) begin
            // one-word closing line left by a read change; waits for space
            if (count_q != c_full) begin
                w_push      = 1'b1;
                w_push_last = 1'b1;
                pk_data_d   = '0;
                wr_idx_d    = '0;
                pend_d      = 1'b0;
            end
        end else if (w_accept) begin
            if ((wr_idx_q != '0) && (bus.token_read_num != cur_read_q)) begin
                w_push     = 1'b1;
                pk_data_d  = w_new_line;
                wr_idx_d   = 4'd1;
                cur_read_d = bus.token_read_num;
                pend_d     = bus.token_last;
            end else if (w_natural || w_flush_req) begin
                // a flush that rides along with the token closes the line here;
                // a flush coinciding with a full/last push waits a cycle
                w_push       = 1'b1;
                w_push_data  = w_tok_line;
                w_push_num   = bus.token_read_num;
                w_push_words = w_new_idx;
                w_push_last  = bus.token_last;
                pk_data_d    = '0;
                wr_idx_d     = '0;
                cur_read_d   = bus.token_read_num;
                fpend_d      = w_flush_req && w_natural;
            end else begin
                pk_data_d  = w_tok_line;
                wr_idx_d   = w_new_idx;
                cur_read_d = bus.token_read_num;
            end
        end else if (w_flush_req && !w_stall) begin
            fpend_d = 1'b0;
            if (wr_idx_q != '0) begin
                w_push    = 1'b1;
                pk_data_d = '0;
                wr_idx_d  = '0;
            end
        end
    end

`ifdef SMEM_PACK_HDR_EN
    // Word 0 becomes the line header: read_num, payload count, last flag.
    always_comb begin
        w_push_out                       = w_push_data;
        w_push_out[63:0]                 = '0;
        w_push_out[READ_NUM_WIDTH-1:0]   = w_push_num;
        w_push_out[19:16]                = w_push_words;
        w_push_out[24]                   = w_push_last;
    end
`else
    assign w_push_out = w_push_data;
`endif

    // Packer registers, FIFO storage/pointers and the delivered-line counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pk_data_q  <= '0;
            wr_idx_q   <= '0;
            cur_read_q <= '0;
            pend_q     <= 1'b0;
            fpend_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lines_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_num_q[i]   <= '0;
                fifo_words_q[i] <= '0;
                fifo_last_q[i]  <= 1'b0;
            end
        end else begin
            pk_data_q  <= pk_data_d;
            wr_idx_q   <= wr_idx_d;
            cur_read_q <= cur_read_d;
            pend_q     <= pend_d;
            fpend_q    <= fpend_d;
            if (w_push) begin
                fifo_data_q[wr_ptr_q]  <= w_push_out;
                fifo_num_q[wr_ptr_q]   <= w_push_num;
                fifo_words_q[wr_ptr_q] <= w_push_words;
                fifo_last_q[wr_ptr_q]  <= w_push_last;
                wr_ptr_q               <= wr_ptr_q + c_aw'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_aw'(1);
                lines_q  <= lines_q + 32'd1;
            end
            count_q <= count_q + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop);
        end
    end

    assign bus.stall       = w_stall;
    assign bus.cl_valid    = w_valid;
    assign bus.cl_data     = w_valid ? fifo_data_q[rd_ptr_q]  : '0;
    assign bus.cl_read_num = w_valid ? fifo_num_q[rd_ptr_q]   : '0;
    assign bus.cl_words    = w_valid ? fifo_words_q[rd_ptr_q] : '0;
    assign bus.cl_last     = w_valid ? fifo_last_q[rd_ptr_q]  : 1'b0;
    assign bus.lines_out   = lines_q;
endmodule
`default_nettype wire

// File: tb/tb_smem_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_smem_result_packer
//  Description : Self-checking bench for smem_result_packer: line-level
//                reference model plus directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_smem_result_packer;
    localparam int DEPTH = 4;
    localparam int RW    = 8;
`ifdef SMEM_PACK_HDR_EN
    localparam int NW   = 7;
    localparam int BASE = 1;
`else
    localparam int NW   = 8;
    localparam int BASE = 0;
`endif

    typedef struct {
        logic [511:0]  data;
        logic [RW-1:0] num;
        logic [3:0]    words;
        logic          last;
    } line_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    smem_result_packer_if #(.READ_NUM_WIDTH(RW)) bus ();
    smem_result_packer #(.DEPTH(DEPTH), .READ_NUM_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    int          el    = 0;
    line_t       exp_q[$];
    logic [63:0] mw[$];
    logic [RW-1:0] mr = '0;
    bit          fp = 1'b0;

    function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endfunction

    function automatic logic [63:0] tok(input int r, input int k);
        return {8'(r), 24'hC0FFEE, 32'(k)};
    endfunction

    // close the model's current line into the expected stream
    function automatic void emit(input logic lst);
        line_t l;
        l.data = '0;
        foreach (mw[i]) l.data[(i+BASE)*64 +: 64] = mw[i];
        l.num   = mr;
        l.words = 4'(mw.size());
        l.last  = lst;
        if (BASE == 1) l.data[63:0] = {39'd0, lst, 4'd0, l.words, 16'd0} | 64'(mr);
        exp_q.push_back(l);
        mw.delete();
    endfunction

    // Compare process + model: outputs are stable at negedge; inputs were
    // driven at posedge+1 and apply at the coming posedge.
    always @(negedge clk) begin
        line_t l;
        bit    pushed;
        if (!rst) begin
            exp_q.delete();
            mw.delete();
            fp   = 1'b0;
            pops = 0;
        end else begin
            chk("lines_out", bus.lines_out, 32'(pops));
            if (bus.cl_valid && bus.cl_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_line", 1'b1, 1'b0);
                end else begin
                    l = exp_q.pop_front();
                    chk("line_data", bus.cl_data, l.data);
                    chk("line_read_num", bus.cl_read_num, l.num);
                    chk("line_words", bus.cl_words, l.words);
                    chk("line_last", bus.cl_last, l.last);
                end
                pops++;
            end
            fp = fp | bus.flush;
            if (!bus.stall) begin
                pushed = 1'b0;
                if (bus.token_valid) begin
                    if (mw.size() != 0 && bus.token_read_num != mr) begin
                        emit(1'b0);
                        pushed = 1'b1;
                    end
                    if (mw.size() == 0) mr = bus.token_read_num;
                    mw.push_back(bus.token_data);
                    if (pushed) begin
                        if (bus.token_last) emit(1'b1);
                    end else if (mw.size() == NW || bus.token_last) begin
                        emit(bus.token_last);
                        pushed = 1'b1;
                    end
                end
                if (!pushed && fp) begin
                    if (mw.size() != 0) emit(1'b0);
                    fp = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [63:0] d, input logic [RW-1:0] rn,
                       input logic lst, input logic fl, input logic rdy);
        bus.token_valid    = v;
        bus.token_data     = d;
        bus.token_read_num = rn;
        bus.token_last     = lst;
        bus.flush          = fl;
        bus.cl_ready       = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) cyc(1'b0, '0, '0, 1'b0, 1'b0, rdy);
    endtask

    // offer a token until accepted (bounded)
    task automatic send(input logic [63:0] d, input logic [RW-1:0] rn, input logic lst, input logic rdy);
        bit acc = 1'b0;
        int b   = 0;
        while (!acc && b < 60) begin
            acc = !bus.stall;
            cyc(1'b1, d, rn, lst, 1'b0, rdy);
            b++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got stall=1 want accepted within 60 cycles");
        end
    endtask

    task automatic drain();
        int b = 0;
        while ((exp_q.size() != 0 || bus.cl_valid) && b < 200) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            b++;
        end
        total++;
        if (exp_q.size() != 0 || bus.cl_valid) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d valid=%0b want 0 0", exp_q.size(), bus.cl_valid);
        end
    endtask

    initial begin
        logic [RW-1:0] rn;
        int            nf;
        bus.token_valid = 1'b0; bus.token_data = '0; bus.token_read_num = '0;
        bus.token_last  = 1'b0; bus.flush = 1'b0;   bus.cl_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_cl_valid", bus.cl_valid, 1'b0);
        chk("rst_cl_data", bus.cl_data, '0);
        chk("rst_cl_read_num", bus.cl_read_num, '0);
        chk("rst_cl_words", bus.cl_words, '0);
        chk("rst_cl_last", bus.cl_last, 1'b0);
        chk("rst_lines_out", bus.lines_out, '0);
        rst = 1'b1;
        idle(1, 1'b1);

`ifndef SMEM_PACK_HDR_EN
        // full line of 8 tokens, last on the 8th
        for (int k = 0; k < 8; k++) send(tok(3, k), 8'd3, k == 7, 1'b1);
        chk("t1_valid", bus.cl_valid, 1'b1);
        chk("t1_words", bus.cl_words, 4'd8);
        chk("t1_last", bus.cl_last, 1'b1);
        chk("t1_read_num", bus.cl_read_num, 8'd3);
        chk("t1_word0", bus.cl_data[63:0], tok(3, 0));
        chk("t1_word7", bus.cl_data[511:448], tok(3, 7));
`else
        // header line: 7 payload tokens for read 2, last on the 7th
        for (int k = 0; k < 7; k++) send(tok(2, k), 8'd2, k == 6, 1'b1);
        chk("hdr_word0", bus.cl_data[63:0], 64'h0000_0000_0107_0002);
        chk("hdr_words", bus.cl_words, 4'd7);
        chk("hdr_word1", bus.cl_data[127:64], tok(2, 0));
        chk("hdr_word7", bus.cl_data[511:448], tok(2, 6));
`endif
        idle(1, 1'b1);
        el = 1;
        chk("t1_lines_out", bus.lines_out, 32'(el));

        // read change closes a partial line
        for (int k = 0; k < 3; k++) send(tok(5, k), 8'd5, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) send(tok(6, k), 8'd6, k == 1, 1'b0);
        chk("t2_read_num", bus.cl_read_num, 8'd5);
        chk("t2_words", bus.cl_words, 4'd3);
        chk("t2_last", bus.cl_last, 1'b0);
        chk("t2_pad_zero", bus.cl_data >> ((BASE + 3) * 64), '0);
        drain();
        el += 2;
        chk("t2_lines_out", bus.lines_out, 32'(el));

        // flush emits a partial line; second flush on empty packer is a no-op
        for (int k = 0; k < 2; k++) send(tok(1, k), 8'd1, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("t3_valid", bus.cl_valid, 1'b1);
        chk("t3_words", bus.cl_words, 4'd2);
        chk("t3_last", bus.cl_last, 1'b0);
        drain();
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        el += 1;
        chk("t3_noop_valid", bus.cl_valid, 1'b0);
        chk("t3_lines_out", bus.lines_out, 32'(el));

        // read change with token_last on the first token: one-cycle stall
        for (int k = 0; k < 4; k++) send(tok(8, k), 8'd8, 1'b0, 1'b0);
        send(tok(9, 0), 8'd9, 1'b1, 1'b0);
        chk("t4_pend_stall", bus.stall, 1'b1);
        chk("t4_read_num", bus.cl_read_num, 8'd8);
        chk("t4_words", bus.cl_words, 4'd4);
        idle(1, 1'b0);
        chk("t4_stall_release", bus.stall, 1'b0);
        drain();
        el += 2;
        chk("t4_lines_out", bus.lines_out, 32'(el));

        // backpressure: FIFO fills, stall holds, then everything drains in order
        nf = DEPTH * NW;
        for (int k = 0; k < nf; k++) send(tok(7, k), 8'd7, 1'b0, 1'b0);
        chk("t5_full_stall", bus.stall, 1'b1);
        repeat (3) cyc(1'b1, tok(7, nf), 8'd7, 1'b0, 1'b0, 1'b0);
        chk("t5_still_stall", bus.stall, 1'b1);
        for (int k = nf; k < 40; k++) send(tok(7, k), 8'd7, k == 39, 1'b1);
        drain();
        el += (40 + NW - 1) / NW;
        chk("t5_lines_out", bus.lines_out, 32'(el));

        // reset mid-operation discards queued and partial lines
        for (int k = 0; k < 2 * NW + 3; k++) send(tok(4, k), 8'd4, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1, 1'b0);
        chk("t6_stall", bus.stall, 1'b0);
        chk("t6_cl_valid", bus.cl_valid, 1'b0);
        chk("t6_cl_data", bus.cl_data, '0);
        chk("t6_cl_read_num", bus.cl_read_num, '0);
        chk("t6_cl_words", bus.cl_words, '0);
        chk("t6_cl_last", bus.cl_last, 1'b0);
        chk("t6_lines_out", bus.lines_out, '0);
        rst = 1'b1;
        idle(5, 1'b1);
        chk("t6_no_stale", bus.cl_valid, 1'b0);

        // random traffic against the model
        rn = '0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) == 0) rn = RW'($urandom_range(0, 3));
            cyc($urandom_range(0, 9) < 7, {$urandom, $urandom}, rn,
                $urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 9) < 6);
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
